// File: rtl/p_i_cache_ctrl_nway_pkg.sv
// Shared types and tree pseudo-LRU helpers for the n-way instruction cache controller.
// PLRU vectors are stored with tree node 0 (the root) in the most significant bit.
package p_i_cache_types;

    localparam int MAX_WAYS = 16;

    typedef enum logic [1:0] {
        CURR_CPU  = 2'd0,
        PREV_CPU  = 2'd1,
        FLUSH_IDX = 2'd2
    } addrsel_t;

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        MISS,
        REFILL,
        FLUSH
    } pcs_state_t;

    // Lowest invalid way wins; otherwise follow the tree bits from the root down to a leaf.
    function automatic int plru_victim(input logic [MAX_WAYS-2:0] bits,
                                       input logic [MAX_WAYS-1:0] valid,
                                       input int ways);
        int node;
        int way;
        way  = -1;
        node = 0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (i < ways && !valid[4'(i)]) way = i;
        end
        if (way < 0) begin
            for (int lvl = 0; lvl < 4; lvl++) begin
                if (node < ways - 1) begin
                    node = bits[4'(ways - 2 - node)] ? 2 * node + 2 : 2 * node + 1;
                end
            end
            way = node - (ways - 1);
        end
        return way;
    endfunction

    function automatic logic [MAX_WAYS-2:0] plru_touch(input logic [MAX_WAYS-2:0] bits,
                                                       input int way,
                                                       input int ways);
        logic [MAX_WAYS-2:0] res;
        int node;
        int lo;
        int span;
        int half;
        res  = bits;
        node = 0;
        lo   = 0;
        span = ways;
        half = 0;
        for (int lvl = 0; lvl < 4; lvl++) begin
            if (node < ways - 1) begin
                half = span / 2;
                if (way < lo + half) begin
                    res[4'(ways - 2 - node)] = 1'b1;
                    node = 2 * node + 1;
                end else begin
                    res[4'(ways - 2 - node)] = 1'b0;
                    node = 2 * node + 2;
                    lo   = lo + half;
                end
                span = half;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/p_i_cache_ctrl_nway_if.sv
// Fetch, arbiter and array-control signals between the cache controller and its datapath.
interface p_i_cache_ctrl_nway_if
    import p_i_cache_types::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 32
) ();

    localparam int IDX_W = $clog2(SETS);

    logic             mem_read;
    logic             mem_resp;
    logic             s1_hit;
    logic             s2_hit;
    logic [WAYS-1:0]  s2_hit_way;
    logic [WAYS-1:0]  s2_valid;
    logic [WAYS-2:0]  s2_plru;
    logic             pmem_read;
    logic             pmem_resp;
    logic             flush_req;
    logic             flush_done;
    logic [WAYS-1:0]  way_load;
    logic             valid_datain;
    logic             plru_load;
    logic [WAYS-2:0]  plru_datain;
    addrsel_t         addr_sel;
    logic [IDX_W-1:0] flush_idx;

    modport master (
        input  mem_read, s1_hit, s2_hit, s2_hit_way, s2_valid, s2_plru, pmem_resp, flush_req,
        output mem_resp, pmem_read, flush_done, way_load, valid_datain, plru_load, plru_datain,
               addr_sel, flush_idx
    );

    modport slave (
        output mem_read, s1_hit, s2_hit, s2_hit_way, s2_valid, s2_plru, pmem_resp, flush_req,
        input  mem_resp, pmem_read, flush_done, way_load, valid_datain, plru_load, plru_datain,
               addr_sel, flush_idx
    );

endinterface

// File: rtl/p_i_cache_ctrl_nway_plru.sv
// Combinational PLRU tree: victim choice for the given set and the bits after touching a way.
module p_plru_tree
    import p_i_cache_types::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0] bits_i,
    input  logic [WAYS-1:0] valid_i,
    input  logic [WAYS-1:0] access_i,
    output logic [WAYS-1:0] victim_o,
    output logic [WAYS-2:0] bits_o
);

    logic [MAX_WAYS-2:0] bitsWide;
    logic [MAX_WAYS-2:0] touchedWide;
    logic [MAX_WAYS-1:0] validWide;
    int                  victimIdx;
    int                  accessIdx;
    logic                unusedTouchedHigh;

    always_comb begin
        bitsWide              = '0;
        bitsWide[WAYS-2:0]    = bits_i;
        validWide             = '0;
        validWide[WAYS-1:0]   = valid_i;
        accessIdx             = 0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (access_i[i]) accessIdx = i;
        end
        victimIdx   = plru_victim(bitsWide, validWide, WAYS);
        touchedWide = plru_touch(bitsWide, accessIdx, WAYS);
        victim_o    = WAYS'(1) << victimIdx;
        bits_o      = touchedWide[WAYS-2:0];
    end

    assign unusedTouchedHigh = ^touchedWide;

endmodule

// File: rtl/p_i_cache_ctrl_nway.sv
// Instruction cache controller: hit/miss/refill sequencing, PLRU maintenance and the
// whole-cache invalidate sweep used by fence.i.
module p_i_cache_ctrl_nway
    import p_i_cache_types::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    p_i_cache_ctrl_nway_if.master cache_io
);

    localparam int                IDX_W    = $clog2(SETS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    pcs_state_t       state_q;
    pcs_state_t       state_d;
    logic [IDX_W-1:0] flushIdx_q;
    logic [IDX_W-1:0] flushIdx_d;

    logic [WAYS-1:0]  victimWay;
    logic [WAYS-1:0]  unusedFillVictim;
    logic [WAYS-2:0]  hitBits;
    logic [WAYS-2:0]  fillBits;

    p_plru_tree #(.WAYS(WAYS)) hitTree (
        .bits_i   (cache_io.s2_plru),
        .valid_i  (cache_io.s2_valid),
        .access_i (cache_io.s2_hit_way),
        .victim_o (victimWay),
        .bits_o   (hitBits)
    );

    // Both trees see the same set, so the hit tree's victim is the way being filled.
    p_plru_tree #(.WAYS(WAYS)) fillTree (
        .bits_i   (cache_io.s2_plru),
        .valid_i  (cache_io.s2_valid),
        .access_i (victimWay),
        .victim_o (unusedFillVictim),
        .bits_o   (fillBits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            flushIdx_q <= '0;
        end else begin
            state_q    <= state_d;
            flushIdx_q <= flushIdx_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        flushIdx_d            = flushIdx_q;
        cache_io.mem_resp     = 1'b0;
        cache_io.pmem_read    = 1'b0;
        cache_io.flush_done   = 1'b0;
        cache_io.way_load     = '0;
        cache_io.valid_datain = 1'b0;
        cache_io.plru_load    = 1'b0;
        cache_io.plru_datain  = '0;
        cache_io.addr_sel     = CURR_CPU;

        case (state_q)
            IDLE: begin
                if (cache_io.flush_req)     state_d = FLUSH;
                else if (cache_io.mem_read) state_d = cache_io.s1_hit ? HIT : MISS;
            end
            HIT: begin
                cache_io.mem_resp    = cache_io.s2_hit;
                cache_io.plru_load   = cache_io.s2_hit;
                cache_io.plru_datain = hitBits;
                if (cache_io.flush_req)     state_d = FLUSH;
                else if (!cache_io.mem_read) state_d = IDLE;
                else if (!cache_io.s1_hit)   state_d = MISS;
            end
            MISS: begin
                cache_io.addr_sel  = PREV_CPU;
                cache_io.pmem_read = 1'b1;
                if (cache_io.pmem_resp) begin
                    cache_io.way_load     = victimWay;
                    cache_io.valid_datain = 1'b1;
                    cache_io.plru_load    = 1'b1;
                    cache_io.plru_datain  = fillBits;
                    state_d               = REFILL;
                end
            end
            REFILL: begin
                cache_io.addr_sel = PREV_CPU;
                state_d           = HIT;
            end
            FLUSH: begin
                cache_io.addr_sel  = FLUSH_IDX;
                cache_io.way_load  = '1;
                cache_io.plru_load = 1'b1;
                if (flushIdx_q == LAST_IDX) begin
                    cache_io.flush_done = 1'b1;
                    flushIdx_d          = '0;
                    state_d             = IDLE;
                end else begin
                    flushIdx_d = flushIdx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cache_io.flush_idx = flushIdx_q;

    hitWayOneHot: assert property (@(posedge clk) disable iff (!rst_n)
        cache_io.s2_hit |-> $onehot(cache_io.s2_hit_way));

endmodule

// File: tb/tb_p_i_cache_ctrl_nway.sv
// Directed bench for p_i_cache_ctrl_nway: fills, PLRU victims, hit streams, flush sweep,
// asynchronous reset and victim choice at 2, 8 and 16 ways.
module tb_p_i_cache_ctrl_nway;
    import p_i_cache_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;
    int   respCount  = 0;

    always #5 clk = ~clk;

    p_i_cache_ctrl_nway_if #(.WAYS(4),  .SETS(32)) bus4  ();
    p_i_cache_ctrl_nway_if #(.WAYS(2),  .SETS(4))  bus2  ();
    p_i_cache_ctrl_nway_if #(.WAYS(8),  .SETS(4))  bus8  ();
    p_i_cache_ctrl_nway_if #(.WAYS(16), .SETS(2))  bus16 ();

    p_i_cache_ctrl_nway #(.WAYS(4),  .SETS(32)) dut4  (.clk(clk), .rst_n(rst_n), .cache_io(bus4));
    p_i_cache_ctrl_nway #(.WAYS(2),  .SETS(4))  dut2  (.clk(clk), .rst_n(rst_n), .cache_io(bus2));
    p_i_cache_ctrl_nway #(.WAYS(8),  .SETS(4))  dut8  (.clk(clk), .rst_n(rst_n), .cache_io(bus8));
    p_i_cache_ctrl_nway #(.WAYS(16), .SETS(2))  dut16 (.clk(clk), .rst_n(rst_n), .cache_io(bus16));

    // Hand-derived PLRU results; node 0 is the MSB of each vector.
    logic [3:0]  hitWayTab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [2:0]  hitPlruTab[4] = '{3'b110, 3'b100, 3'b001, 3'b000};

    logic [1:0]  sw2Valid[4] = '{2'b01, 2'b11, 2'b11, 2'b00};
    logic [0:0]  sw2Plru [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  sw2Load [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
    logic [0:0]  sw2New  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    logic [7:0]  sw8Valid[4] = '{8'h07, 8'hFF, 8'hFF, 8'hFE};
    logic [6:0]  sw8Plru [4] = '{7'h00, 7'h00, 7'h68, 7'h3A};
    logic [7:0]  sw8Load [4] = '{8'h08, 8'h01, 8'h10, 8'h01};
    logic [6:0]  sw8New  [4] = '{7'h40, 7'h68, 7'h3A, 7'h7A};

    logic [15:0] sw16Valid[4] = '{16'hEDFF, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    logic [14:0] sw16Plru [4] = '{15'h0000, 15'h7FFF, 15'h0000, 15'h0000};
    logic [15:0] sw16Load [4] = '{16'h0200, 16'h8000, 16'h0001, 16'h8000};
    logic [14:0] sw16New  [4] = '{15'h1200, 15'h2EFE, 15'h6880, 15'h0000};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic read, input logic hit1, input logic hit2,
                                 input logic [3:0] hitWay);
        bus4.mem_read   = read;
        bus4.s1_hit     = hit1;
        bus4.s2_hit     = hit2;
        bus4.s2_hit_way = hitWay;
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        bus4.s2_valid = '0;  bus4.s2_plru = '0;  bus4.pmem_resp = 1'b0;  bus4.flush_req = 1'b0;
        bus2.mem_read = 1'b0; bus2.s1_hit = 1'b0; bus2.s2_hit = 1'b0; bus2.s2_hit_way = '0;
        bus2.s2_valid = '0;  bus2.s2_plru = '0;  bus2.pmem_resp = 1'b0;  bus2.flush_req = 1'b0;
        bus8.mem_read = 1'b0; bus8.s1_hit = 1'b0; bus8.s2_hit = 1'b0; bus8.s2_hit_way = '0;
        bus8.s2_valid = '0;  bus8.s2_plru = '0;  bus8.pmem_resp = 1'b0;  bus8.flush_req = 1'b0;
        bus16.mem_read = 1'b0; bus16.s1_hit = 1'b0; bus16.s2_hit = 1'b0; bus16.s2_hit_way = '0;
        bus16.s2_valid = '0; bus16.s2_plru = '0; bus16.pmem_resp = 1'b0; bus16.flush_req = 1'b0;
    endtask

    // One complete miss: request, arbiter wait, fill, re-lookup and the hit response at k+2.
    task automatic runMiss(input logic [3:0] valid, input logic [2:0] plru, input logic [3:0] expWay,
                           input logic [2:0] expPlru, input int waitCycles, input string tag);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        bus4.s2_valid = valid;
        bus4.s2_plru  = plru;
        #1 checkOutput({tag, " idle pmem_read"}, 32'(bus4.pmem_read), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        #1 checkOutput({tag, " miss pmem_read"}, 32'(bus4.pmem_read), 32'd1);
        checkOutput({tag, " miss addr_sel"}, 32'(bus4.addr_sel), 32'(PREV_CPU));
        for (int i = 0; i < waitCycles; i++) begin
            @(negedge clk);
            #1 checkOutput({tag, " wait way_load"}, 32'(bus4.way_load), 32'd0);
        end
        @(negedge clk);
        bus4.pmem_resp = 1'b1;
        #1 checkOutput({tag, " fill way_load"}, 32'(bus4.way_load), 32'(expWay));
        checkOutput({tag, " fill valid_datain"}, 32'(bus4.valid_datain), 32'd1);
        checkOutput({tag, " fill plru_load"}, 32'(bus4.plru_load), 32'd1);
        checkOutput({tag, " fill plru_datain"}, 32'(bus4.plru_datain), 32'(expPlru));
        @(negedge clk);
        bus4.pmem_resp = 1'b0;
        bus4.s2_plru   = expPlru;
        applyStimulus(1'b0, 1'b0, 1'b1, expWay);
        #1 checkOutput({tag, " refill addr_sel"}, 32'(bus4.addr_sel), 32'(PREV_CPU));
        checkOutput({tag, " refill mem_resp"}, 32'(bus4.mem_resp), 32'd0);
        @(negedge clk);
        #1 checkOutput({tag, " hit mem_resp"}, 32'(bus4.mem_resp), 32'd1);
        checkOutput({tag, " hit plru_datain"}, 32'(bus4.plru_datain), 32'(expPlru));
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        #1 checkOutput({tag, " back to idle"}, 32'(bus4.mem_resp), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        @(negedge clk);
        #1 checkOutput("reset mem_resp", 32'(bus4.mem_resp), 32'd0);
        checkOutput("reset pmem_read", 32'(bus4.pmem_read), 32'd0);
        checkOutput("reset way_load", 32'(bus4.way_load), 32'd0);
        checkOutput("reset plru_load", 32'(bus4.plru_load), 32'd0);
        checkOutput("reset addr_sel", 32'(bus4.addr_sel), 32'(CURR_CPU));
        checkOutput("reset flush_idx", 32'(bus4.flush_idx), 32'd0);
        checkOutput("reset flush_done", 32'(bus4.flush_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runMiss(4'b0000, 3'b000, 4'b0001, 3'b110, 1, "fill0");
        runMiss(4'b0001, 3'b110, 4'b0010, 3'b100, 0, "fill1");
        runMiss(4'b0011, 3'b100, 4'b0100, 3'b001, 2, "fill2");
        runMiss(4'b0111, 3'b001, 4'b1000, 3'b000, 0, "fill3");
        runMiss(4'b1111, 3'b000, 4'b0001, 3'b110, 0, "evict0");
        runMiss(4'b1111, 3'b110, 4'b0100, 3'b011, 0, "evict2");

        // Eight sequential hits, one response per cycle.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        bus4.s2_plru = 3'b000;
        #1 checkOutput("stream idle mem_resp", 32'(bus4.mem_resp), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(i < 7, 1'b1, 1'b1, hitWayTab[i % 4]);
            #1 if (bus4.mem_resp) respCount++;
            checkOutput($sformatf("stream plru_load %0d", i), 32'(bus4.plru_load), 32'd1);
            checkOutput($sformatf("stream plru_datain %0d", i), 32'(bus4.plru_datain), 32'(hitPlruTab[i % 4]));
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        #1 checkOutput("stream end mem_resp", 32'(bus4.mem_resp), 32'd0);
        checkOutput("stream response count", 32'(respCount), 32'd8);

        // Flush requested while a miss is outstanding.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        bus4.s2_valid = 4'b0011;
        bus4.s2_plru  = 3'b000;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        bus4.flush_req = 1'b1;
        #1 checkOutput("flushmiss pmem_read", 32'(bus4.pmem_read), 32'd1);
        @(negedge clk);
        #1 checkOutput("flushmiss still miss", 32'(bus4.addr_sel), 32'(PREV_CPU));
        @(negedge clk);
        bus4.pmem_resp = 1'b1;
        #1 checkOutput("flushmiss way_load", 32'(bus4.way_load), 32'b0100);
        checkOutput("flushmiss plru_datain", 32'(bus4.plru_datain), 32'b001);
        @(negedge clk);
        bus4.pmem_resp = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0100);
        #1 checkOutput("flushmiss refill addr_sel", 32'(bus4.addr_sel), 32'(PREV_CPU));
        @(negedge clk);
        #1 checkOutput("flushmiss hit mem_resp", 32'(bus4.mem_resp), 32'd1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            #1 checkOutput($sformatf("sweep way_load %0d", i), 32'(bus4.way_load), 32'hF);
            checkOutput($sformatf("sweep flush_idx %0d", i), 32'(bus4.flush_idx), 32'(i));
            checkOutput($sformatf("sweep flush_done %0d", i), 32'(bus4.flush_done), 32'(i == 31));
            checkOutput($sformatf("sweep mem_resp %0d", i), 32'(bus4.mem_resp), 32'd0);
            if (i == 0) begin
                checkOutput("sweep addr_sel", 32'(bus4.addr_sel), 32'(FLUSH_IDX));
                checkOutput("sweep valid_datain", 32'(bus4.valid_datain), 32'd0);
                checkOutput("sweep plru_load", 32'(bus4.plru_load), 32'd1);
                checkOutput("sweep plru_datain", 32'(bus4.plru_datain), 32'd0);
            end
            if (i == 31) bus4.flush_req = 1'b0;
        end
        runMiss(4'b0000, 3'b000, 4'b0001, 3'b110, 0, "postflush");

        // Asynchronous reset partway through a sweep.
        @(negedge clk);
        bus4.flush_req = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #1 checkOutput("midflush flush_idx", 32'(bus4.flush_idx), 32'd5);
        #1 rst_n = 1'b0;
        #1 checkOutput("midflush rst flush_idx", 32'(bus4.flush_idx), 32'd0);
        checkOutput("midflush rst way_load", 32'(bus4.way_load), 32'd0);
        checkOutput("midflush rst plru_load", 32'(bus4.plru_load), 32'd0);
        checkOutput("midflush rst addr_sel", 32'(bus4.addr_sel), 32'(CURR_CPU));
        checkOutput("midflush rst flush_done", 32'(bus4.flush_done), 32'd0);
        bus4.flush_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while waiting on the arbiter.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        #1 checkOutput("midmiss pmem_read", 32'(bus4.pmem_read), 32'd1);
        rst_n = 1'b0;
        #1 checkOutput("midmiss rst pmem_read", 32'(bus4.pmem_read), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 checkOutput("after rst pmem_read", 32'(bus4.pmem_read), 32'd0);

        // Victim choice and PLRU update at other associativities.
        @(negedge clk);
        bus2.mem_read = 1'b1; bus8.mem_read = 1'b1; bus16.mem_read = 1'b1;
        @(negedge clk);
        bus2.mem_read = 1'b0; bus8.mem_read = 1'b0; bus16.mem_read = 1'b0;
        #1 checkOutput("w2 pmem_read", 32'(bus2.pmem_read), 32'd1);
        checkOutput("w8 pmem_read", 32'(bus8.pmem_read), 32'd1);
        checkOutput("w16 pmem_read", 32'(bus16.pmem_read), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus2.s2_valid  = sw2Valid[i];  bus2.s2_plru  = sw2Plru[i];  bus2.pmem_resp  = 1'b1;
            bus8.s2_valid  = sw8Valid[i];  bus8.s2_plru  = sw8Plru[i];  bus8.pmem_resp  = 1'b1;
            bus16.s2_valid = sw16Valid[i]; bus16.s2_plru = sw16Plru[i]; bus16.pmem_resp = 1'b1;
            #1 checkOutput($sformatf("w2 way_load %0d", i), 32'(bus2.way_load), 32'(sw2Load[i]));
            checkOutput($sformatf("w2 plru_datain %0d", i), 32'(bus2.plru_datain), 32'(sw2New[i]));
            checkOutput($sformatf("w8 way_load %0d", i), 32'(bus8.way_load), 32'(sw8Load[i]));
            checkOutput($sformatf("w8 plru_datain %0d", i), 32'(bus8.plru_datain), 32'(sw8New[i]));
            checkOutput($sformatf("w16 way_load %0d", i), 32'(bus16.way_load), 32'(sw16Load[i]));
            checkOutput($sformatf("w16 plru_datain %0d", i), 32'(bus16.plru_datain), 32'(sw16New[i]));
            bus2.pmem_resp = 1'b0; bus8.pmem_resp = 1'b0; bus16.pmem_resp = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/p_i_cache_ctrl_nway.md
# p_i_cache_ctrl_nway

Parametrised control unit for the two-stage pipelined instruction cache. It supports any power-of-two associativity with tree pseudo-LRU replacement, refreshes PLRU state on refill as well as on hit, and adds a whole-cache invalidate sweep for `fence.i`. It sits between the fetch stage and the arbiter. It drives the tag/valid/data/PLRU array write enables and the array address mux; the arrays and the stage-1/stage-2 pipeline register stay in the datapath.

## Interface
Parameters:
- `WAYS`, default 4: associativity; power of two, 2..16.
- `SETS`, default 32: sets per way; power of two, ≥2.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `mem_read`, in, 1: fetch request present in stage 1.
- `mem_resp`, out, 1: stage-2 request served this cycle.
- `s1_hit`, in, 1: combinational hit of the stage-1 lookup.
- `s2_hit`, in, 1: registered hit of the stage-2 request.
- `s2_hit_way`, in, WAYS: one-hot hit way of the stage-2 request.
- `s2_valid`, in, WAYS: valid bits of the stage-2 set.
- `s2_plru`, in, WAYS-1: PLRU tree bits of the stage-2 set.
- `pmem_read`, out, 1: line read request to the arbiter.
- `pmem_resp`, in, 1: line data valid, single cycle.
- `flush_req`, in, 1: invalidate-all request, level until `flush_done`.
- `flush_done`, out, 1: one-cycle pulse on the last sweep cycle.
- `way_load`, out, WAYS: tag/valid/data write enable per way.
- `valid_datain`, out, 1: value written to the valid bits.
- `plru_load`, out, 1: PLRU array write enable.
- `plru_datain`, out, WAYS-1: new PLRU bits.
- `addr_sel`, out, `addrsel_t`: array index source, one of `CURR_CPU`, `PREV_CPU`, `FLUSH_IDX`.
- `flush_idx`, out, $clog2(SETS): set index during the sweep.

## Operation
- States: `IDLE`, `HIT`, `MISS`, `REFILL`, `FLUSH`. Reset state is `IDLE`.
- Output defaults in every state, and the reset values of all outputs: everything 0, `addr_sel=CURR_CPU`.

PLRU tree:
- Heap-ordered nodes: node 0 is the root; node i has children 2i+1 and 2i+2.
- Bit 0 means the victim lies in the lower-indexed half; bit 1 means the upper half.
- Touching way w sets every node on w's path to point away from w.

Victim selection:
- Lowest-indexed way with `s2_valid=0`.
- Otherwise the way reached by walking the tree from the root.

State behaviour:
- `IDLE`:
  - `flush_req` → `FLUSH`.
  - Else `mem_read & s1_hit` → `HIT`.
  - Else `mem_read & !s1_hit` → `MISS`.
- `HIT`:
  - `mem_resp=s2_hit`; `plru_load=s2_hit`; `plru_datain` = touch(`s2_plru`, `s2_hit_way`).
  - Next state, in priority order: `flush_req` → `FLUSH`; `!mem_read` → `IDLE`; `!s1_hit` → `MISS`; else stay in `HIT`.
- `MISS`:
  - `addr_sel=PREV_CPU`; `pmem_read=1` until `pmem_resp`.
  - On the `pmem_resp` cycle:
    - `way_load` = one-hot victim; `valid_datain=1`.
    - `plru_load=1`; `plru_datain` = touch(`s2_plru`, victim).
    - Next state `REFILL`.
- `REFILL`:
  - `addr_sel=PREV_CPU` (re-lookup of the filled line); next state `HIT`.
  - `flush_req` is not taken here; it waits for `HIT`.
- `FLUSH`:
  - `addr_sel=FLUSH_IDX`; all `way_load` bits 1; `valid_datain=0`; `plru_load=1`; `plru_datain=0`.
  - `flush_idx` counts 0..SETS-1, one set per cycle.
  - At `SETS-1`: `flush_done=1`, counter clears, next state `IDLE`.
  - `mem_resp` stays 0 throughout the sweep.

Boundary conditions:
- A flush is never taken in `MISS` or `REFILL`. The outstanding line completes, then the flush starts after the `HIT` response.
- `s2_hit_way` that is not one-hot while `s2_hit=1` is illegal and is flagged by an assertion.
- Reset mid-miss or mid-flush: state returns to `IDLE` and the counter to 0. `pmem_read` deasserts immediately (asynchronously).
- `WAYS=2`: the tree is a single bit.

## Timing
- Hit: request in stage 1 at cycle t; `mem_resp` at t+1. Back-to-back hits give one response per cycle.
- Miss: `MISS` is entered at t+1 and `pmem_read` is asserted from t+1. With `pmem_resp` at cycle k, the arrays are written at the k edge, `REFILL` is at k+1, and `mem_resp` is at k+2.
- Flush: SETS cycles from `FLUSH` entry; `flush_done` is on the final cycle.
- `pmem_read` is Moore (state-only). `way_load` and `plru_load` are combinational and take effect at the next edge.

## Structure
- Package `p_i_cache_types`:
  - `addrsel_t` enum.
  - `pcs_state_t` enum.
  - `plru_victim` and `plru_touch` functions, parametrised by WAYS.
- Sub-module `p_plru_tree`: combinational; inputs bits, valid, access way; outputs victim one-hot and updated bits. It is instantiated twice: hit-update and fill-update.
- The flush counter is local to the controller.

## Test plan
- WAYS=4, empty cache, fetch 0x100:
  - Required: MISS; fill into way 0 with `valid_datain=1`; `plru_datain=3'b110`; `mem_resp` at k+2.
- Four fills into one set, then a fetch to a fifth tag with PLRU bits `000`:
  - Required: victim is way 0.
  - After touching way 0 the bits are `110`, so the next victim is way 2.
- Back-to-back hits on 8 sequential words:
  - Required: 8 consecutive `mem_resp` cycles; PLRU written each cycle.
- `flush_req` raised during a miss:
  - Required: the fill and response complete first.
  - Then the sweep runs for SETS cycles with all `way_load` bits high, `flush_done` pulses on the last cycle, and a later fetch misses.
- `rst_n` low mid-flush at `flush_idx=5`:
  - Required: immediate return to `IDLE`; all outputs at reset values; `flush_idx=0`.
- Parameter sweep WAYS ∈ {2, 8, 16}:
  - Required: victim always the lowest-indexed invalid way, then PLRU order; no duplicate `way_load` bits.
